// File: rtl/snake_head_ctrl.sv
// snake_head_ctrl: per-frame snake head game logic feeding the pixel renderer.
// Samples a vertical-blanking tick from the scan counters, latches direction
// requests, steps the head, and flags wall collisions and prey hits.
module snake_head_ctrl #(
  parameter int unsigned STEP            = 10,
  parameter int unsigned FRAMES_PER_MOVE = 4,
  parameter int unsigned X_MIN           = 15,
  parameter int unsigned X_MAX           = 630,
  parameter int unsigned Y_MIN           = 15,
  parameter int unsigned Y_MAX           = 465,
  parameter int unsigned X_INIT          = 20,
  parameter int unsigned Y_INIT          = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [9:0] prey_x,
  input  logic [9:0] prey_y,
  output logic [9:0] head_x,
  output logic [9:0] head_y,
  output logic [1:0] dir,
  output logic       eat_pulse,
  output logic [7:0] score,
  output logic       game_over
);

  localparam int unsigned POS_W     = 10;
  localparam int unsigned EXT_W     = 11;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned SCORE_W   = 8;
  localparam int unsigned BOX       = 10;
  localparam int unsigned SCORE_MAX = 255;
  localparam int unsigned TICK_V    = 480;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10
  } state_t;

  state_t state, state_nx;

  logic [3:0]         btn_meta;
  logic [3:0]         btn_s;
  logic               frame_tick;
  logic               btn_any;
  logic [1:0]         req_dir;

  logic               pend_valid, pend_valid_nx;
  logic [1:0]         pend_dir, pend_dir_nx;
  logic               armed, armed_nx;
  logic [CNT_W-1:0]   move_cnt, move_cnt_nx;
  logic [POS_W-1:0]   head_x_nx, head_y_nx;
  logic [1:0]         dir_nx;
  logic               eat_nx;
  logic [SCORE_W-1:0] score_nx;

  logic               move;
  logic [1:0]         new_dir;
  logic               wall;
  logic               hit;
  logic [EXT_W-1:0]   ext_x, ext_y, ext_px, ext_py;
  logic [EXT_W-1:0]   next_x, next_y;
  logic [EXT_W-1:0]   dx, dy;

  // Two-flop synchronizer for the raw buttons; bit order {up, down, left, right}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '0;
      btn_s    <= '0;
    end else begin
      btn_meta <= {btn_up, btn_down, btn_left, btn_right};
      btn_s    <= btn_meta;
    end
  end

  // First blanking line start marks the once-per-frame update slot.
  assign frame_tick = (h_count == POS_W'(0)) && (v_count == POS_W'(TICK_V));

  // Priority-encode the synchronized buttons into a direction request.
  always_comb begin
    btn_any = |btn_s;
    if (btn_s[3])      req_dir = DIR_UP;
    else if (btn_s[2]) req_dir = DIR_DOWN;
    else if (btn_s[1]) req_dir = DIR_LEFT;
    else               req_dir = DIR_RIGHT;
  end

  // Move decode: effective direction, wall test, candidate position, prey overlap.
  always_comb begin
    move    = (state == RUN) && frame_tick &&
              (move_cnt == CNT_W'(FRAMES_PER_MOVE - 1));
    new_dir = pend_valid ? pend_dir : dir;
    ext_x   = EXT_W'(head_x);
    ext_y   = EXT_W'(head_y);
    ext_px  = EXT_W'(prey_x);
    ext_py  = EXT_W'(prey_y);
    wall    = 1'b0;
    next_x  = ext_x;
    next_y  = ext_y;
    case (new_dir)
      DIR_RIGHT: begin
        wall   = (ext_x + EXT_W'(STEP)) > EXT_W'(X_MAX - BOX);
        next_x = ext_x + EXT_W'(STEP);
      end
      DIR_LEFT: begin
        wall   = ext_x < EXT_W'(X_MIN + STEP);
        next_x = ext_x - EXT_W'(STEP);
      end
      DIR_UP: begin
        wall   = ext_y < EXT_W'(Y_MIN + STEP);
        next_y = ext_y - EXT_W'(STEP);
      end
      DIR_DOWN: begin
        wall   = (ext_y + EXT_W'(STEP)) > EXT_W'(Y_MAX - BOX);
        next_y = ext_y + EXT_W'(STEP);
      end
      default: ;
    endcase
    dx  = (next_x >= ext_px) ? (next_x - ext_px) : (ext_px - next_x);
    dy  = (next_y >= ext_py) ? (next_y - ext_py) : (ext_py - next_y);
    hit = (dx < EXT_W'(BOX)) && (dy < EXT_W'(BOX));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (btn_any) state_nx = RUN;
      RUN:     if (move && wall) state_nx = OVER;
      OVER:    if (armed && btn_any) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM output logic: next values for head, direction, score and bookkeeping.
  always_comb begin
    logic [1:0] dir_ref;
    head_x_nx     = head_x;
    head_y_nx     = head_y;
    dir_nx        = dir;
    eat_nx        = 1'b0;
    score_nx      = score;
    pend_valid_nx = pend_valid;
    pend_dir_nx   = pend_dir;
    armed_nx      = 1'b0;
    move_cnt_nx   = '0;
    dir_ref       = dir;
    case (state)
      IDLE: begin
        // The first press starts the game and becomes the first request unfiltered.
        if (btn_any) begin
          pend_valid_nx = 1'b1;
          pend_dir_nx   = req_dir;
        end
      end
      RUN: begin
        if (frame_tick) move_cnt_nx = move ? '0 : move_cnt + CNT_W'(1);
        else            move_cnt_nx = move_cnt;
        if (move) begin
          dir_nx        = new_dir;
          dir_ref       = new_dir;
          pend_valid_nx = 1'b0;
          if (!wall) begin
            head_x_nx = POS_W'(next_x);
            head_y_nx = POS_W'(next_y);
            if (hit) begin
              eat_nx   = 1'b1;
              score_nx = (score == SCORE_W'(SCORE_MAX)) ? score : score + SCORE_W'(1);
            end
          end
        end
        // Reverse is judged against the direction in force after this cycle.
        if (btn_any && (req_dir != (dir_ref ^ 2'b01))) begin
          pend_valid_nx = 1'b1;
          pend_dir_nx   = req_dir;
        end
      end
      OVER: begin
        armed_nx = armed || !btn_any;
        if (armed && btn_any) begin
          head_x_nx     = POS_W'(X_INIT);
          head_y_nx     = POS_W'(Y_INIT);
          dir_nx        = DIR_RIGHT;
          score_nx      = '0;
          pend_valid_nx = 1'b0;
          armed_nx      = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_x     <= POS_W'(X_INIT);
      head_y     <= POS_W'(Y_INIT);
      dir        <= DIR_RIGHT;
      eat_pulse  <= 1'b0;
      score      <= '0;
      game_over  <= 1'b0;
      pend_valid <= 1'b0;
      pend_dir   <= DIR_RIGHT;
      armed      <= 1'b0;
      move_cnt   <= '0;
    end else begin
      head_x     <= head_x_nx;
      head_y     <= head_y_nx;
      dir        <= dir_nx;
      eat_pulse  <= eat_nx;
      score      <= score_nx;
      game_over  <= (state_nx == OVER);
      pend_valid <= pend_valid_nx;
      pend_dir   <= pend_dir_nx;
      armed      <= armed_nx;
      move_cnt   <= move_cnt_nx;
    end
  end

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Directed bench for snake_head_ctrl: scan counters are driven directly so
// each frame is a single (0,480) cycle followed by a short gap.
module tb_snake_head_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] h_count, v_count;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [9:0] prey_x, prey_y;
  logic [9:0] head_x, head_y;
  logic [1:0] dir;
  logic       eat_pulse;
  logic [7:0] score;
  logic       game_over;

  int tests = 0;
  int fails = 0;

  snake_head_ctrl dut (
    .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .prey_x(prey_x), .prey_y(prey_y), .head_x(head_x), .head_y(head_y),
    .dir(dir), .eat_pulse(eat_pulse), .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One tick cycle; returns on the falling edge right after the tick edge.
  task automatic tick();
    h_count = 10'd0; v_count = 10'd480;
    @(negedge clk);
    h_count = 10'd100; v_count = 10'd100;
  endtask

  task automatic frames(input int n);
    repeat (n) begin tick(); cyc(2); end
  endtask

  // b: 0 right, 1 left, 2 up, 3 down (same coding as dir).
  task automatic press(input int b, input int n);
    case (b)
      0: btn_right = 1'b1;
      1: btn_left  = 1'b1;
      2: btn_up    = 1'b1;
      default: btn_down = 1'b1;
    endcase
    cyc(n);
    btn_right = 1'b0; btn_left = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    h_count = 10'd400; v_count = 10'd200;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    prey_x = 10'd40; prey_y = 10'd20;
    cyc(4);
    tests++; if (head_x !== 10'd20 || head_y !== 10'd20) begin fails++; $display("FAIL reset_head: got (%0d,%0d) want (20,20)", head_x, head_y); end
    tests++; if (dir !== 2'b00 || score !== 8'd0) begin fails++; $display("FAIL reset_dir_score: got dir=%b score=%0d want 00/0", dir, score); end
    tests++; if (game_over !== 1'b0 || eat_pulse !== 1'b0) begin fails++; $display("FAIL reset_flags: got go=%b eat=%b want 0/0", game_over, eat_pulse); end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_idle();
    frames(10);
    tests++; if (head_x !== 10'd20 || head_y !== 10'd20 || dir !== 2'b00) begin fails++; $display("FAIL idle_hold: got (%0d,%0d) dir=%b want (20,20) 00", head_x, head_y, dir); end
  endtask

  task automatic test_right_motion();
    press(0, 100);
    frames(3);
    tests++; if (head_x !== 10'd20) begin fails++; $display("FAIL right_pre: got x=%0d want 20", head_x); end
    tick();
    tests++; if (head_x !== 10'd30 || head_y !== 10'd20) begin fails++; $display("FAIL right_step1: got (%0d,%0d) want (30,20)", head_x, head_y); end
    tests++; if (eat_pulse !== 1'b0 || score !== 8'd0) begin fails++; $display("FAIL right_no_eat: got eat=%b score=%0d want 0/0", eat_pulse, score); end
    cyc(2);
  endtask

  task automatic test_prey();
    frames(3);
    tests++; if (head_x !== 10'd30 || eat_pulse !== 1'b0) begin fails++; $display("FAIL prey_pre: got x=%0d eat=%b want 30/0", head_x, eat_pulse); end
    tick();
    tests++; if (head_x !== 10'd40 || head_y !== 10'd20) begin fails++; $display("FAIL prey_step: got (%0d,%0d) want (40,20)", head_x, head_y); end
    tests++; if (eat_pulse !== 1'b1 || score !== 8'd1) begin fails++; $display("FAIL prey_hit: got eat=%b score=%0d want 1/1", eat_pulse, score); end
    cyc(1);
    tests++; if (eat_pulse !== 1'b0) begin fails++; $display("FAIL prey_pulse_width: got eat=%b want 0", eat_pulse); end
    cyc(1);
    prey_x = 10'd300; prey_y = 10'd400;
  endtask

  task automatic test_reverse();
    press(1, 5);
    frames(4);
    tests++; if (head_x !== 10'd50 || dir !== 2'b00) begin fails++; $display("FAIL rev_ignored: got x=%0d dir=%b want 50/00", head_x, dir); end
    press(3, 5);
    btn_left = 1'b1;
    frames(4);
    tests++; if (head_x !== 10'd50 || head_y !== 10'd30 || dir !== 2'b11) begin fails++; $display("FAIL rev_turn_down: got (%0d,%0d) dir=%b want (50,30) 11", head_x, head_y, dir); end
    cyc(5);
    btn_left = 1'b0;
    frames(4);
    tests++; if (head_x !== 10'd40 || head_y !== 10'd30 || dir !== 2'b01) begin fails++; $display("FAIL rev_then_left: got (%0d,%0d) dir=%b want (40,30) 01", head_x, head_y, dir); end
  endtask

  task automatic test_wall();
    int ex;
    press(3, 5);
    frames(4);
    tests++; if (head_x !== 10'd40 || head_y !== 10'd40) begin fails++; $display("FAIL wall_setup: got (%0d,%0d) want (40,40)", head_x, head_y); end
    press(0, 5);
    ex = 40;
    while (ex < 620) begin
      frames(4);
      ex += 10;
      tests++; if (head_x !== 10'(ex) || game_over !== 1'b0) begin fails++; $display("FAIL wall_run: got x=%0d go=%b want %0d/0", head_x, game_over, ex); end
    end
    btn_right = 1'b1;
    frames(4);
    tests++; if (game_over !== 1'b1 || head_x !== 10'd620 || head_y !== 10'd40) begin fails++; $display("FAIL wall_hit: got go=%b (%0d,%0d) want 1 (620,40)", game_over, head_x, head_y); end
    frames(8);
    tests++; if (game_over !== 1'b1 || head_x !== 10'd620 || score !== 8'd1 || eat_pulse !== 1'b0) begin fails++; $display("FAIL wall_frozen: got go=%b x=%0d score=%0d eat=%b", game_over, head_x, score, eat_pulse); end
  endtask

  task automatic test_restart();
    cyc(20);
    tests++; if (game_over !== 1'b1) begin fails++; $display("FAIL restart_held: got go=%b want 1", game_over); end
    btn_right = 1'b0;
    cyc(5);
    btn_down = 1'b1; btn_right = 1'b1;
    cyc(6);
    btn_down = 1'b0; btn_right = 1'b0;
    cyc(2);
    tests++; if (game_over !== 1'b0 || score !== 8'd0) begin fails++; $display("FAIL restart_flags: got go=%b score=%0d want 0/0", game_over, score); end
    tests++; if (head_x !== 10'd20 || head_y !== 10'd20 || dir !== 2'b00) begin fails++; $display("FAIL restart_head: got (%0d,%0d) dir=%b want (20,20) 00", head_x, head_y, dir); end
  endtask

  // Serpentine path with the prey always placed on the next cell.
  task automatic test_saturation();
    int ex, ey, d, edir, cur_h, nx, ny, escore;
    ex = 20; ey = 20; edir = 3; cur_h = 0;
    for (int k = 1; k <= 256; k++) begin
      if (k == 1) d = 3;
      else if (cur_h == 0 && ex == 620) begin d = 3; cur_h = 1; end
      else if (cur_h == 1 && ex == 20) begin d = 3; cur_h = 0; end
      else d = cur_h;
      if (k > 1 && d != edir) begin press(d, 3); cyc(3); end
      edir = d;
      nx = ex; ny = ey;
      case (d)
        0: nx = ex + 10;
        1: nx = ex - 10;
        default: ny = ey + 10;
      endcase
      prey_x = 10'(nx); prey_y = 10'(ny);
      frames(3);
      tick();
      ex = nx; ey = ny;
      escore = (k > 255) ? 255 : k;
      tests++; if (head_x !== 10'(ex) || head_y !== 10'(ey)) begin fails++; $display("FAIL sat_pos k=%0d: got (%0d,%0d) want (%0d,%0d)", k, head_x, head_y, ex, ey); end
      tests++; if (eat_pulse !== 1'b1 || score !== 8'(escore)) begin fails++; $display("FAIL sat_score k=%0d: got eat=%b score=%0d want 1/%0d", k, eat_pulse, score, escore); end
      if (k == 1) begin
        tests++; if (dir !== 2'b11) begin fails++; $display("FAIL restart_priority: got dir=%b want 11", dir); end
      end
      cyc(2);
    end
    tests++; if (eat_pulse !== 1'b0 || score !== 8'd255) begin fails++; $display("FAIL sat_final: got eat=%b score=%0d want 0/255", eat_pulse, score); end
  endtask

  task automatic test_reset_mid();
    prey_x = 10'd300; prey_y = 10'd400;
    frames(3);
    h_count = 10'd0; v_count = 10'd480;
    rst_n = 1'b0;
    #1;
    tests++; if (head_x !== 10'd20 || head_y !== 10'd20 || score !== 8'd0) begin fails++; $display("FAIL reset_async: got (%0d,%0d) score=%0d want (20,20)/0", head_x, head_y, score); end
    cyc(2);
    h_count = 10'd100; v_count = 10'd100;
    rst_n = 1'b1;
    cyc(2);
    tests++; if (head_x !== 10'd20 || head_y !== 10'd20 || dir !== 2'b00 || game_over !== 1'b0 || eat_pulse !== 1'b0) begin fails++; $display("FAIL reset_mid_after: got (%0d,%0d) dir=%b go=%b eat=%b", head_x, head_y, dir, game_over, eat_pulse); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_right_motion();
    test_prey();
    test_reverse();
    test_wall();
    test_restart();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
